// File: rtl/boot_loader.sv
// Boot loader: fills program RAM from a length-prefixed big-endian byte stream,
// then releases VerySimpleCPU from reset and hands it the RAM port.
module boot_loader #(
    parameter int SIZE  = 14,
    parameter int DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      i_byte,
    input  logic            i_byte_valid,
    output logic            o_byte_ready,
    output logic            o_cpu_rst,
    output logic            o_done,
    output logic            o_err,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [31:0]     cpu_data,
    output logic            ram_wrEn,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_data
);

    localparam int          CW      = SIZE + 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0,
        S_HDR_LO = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [CW-1:0]   word_cnt_r;
    logic [1:0]      byte_cnt_r;
    logic [7:0]      len_hi_r;
    logic [15:0]     len_r;
    logic [31:0]     word_r;
    logic            cpu_rst_r;
    logic            done_r;
    logic            err_r;

    logic            ready_s;
    logic            accept_s;
    logic [15:0]     hdr_len_s;
    logic            last_word_s;

    assign accept_s    = ready_s && i_byte_valid;
    assign hdr_len_s   = {len_hi_r, i_byte};
    assign last_word_s = ((32'(word_cnt_r) + 32'd1) == 32'(len_r));

    // Byte acceptance: only header and data-collection states take bytes.
    always_comb begin
        ready_s = 1'b0;
        if (rst) begin
            ready_s = 1'b0;
        end else begin
            case (state_r)
                S_HDR_HI, S_HDR_LO, S_DATA: ready_s = 1'b1;
                default:                    ready_s = 1'b0;
            endcase
        end
    end

    // Next-state logic of the load sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_HDR_HI: begin
                if (accept_s) state_next_s = S_HDR_LO;
                else          state_next_s = S_HDR_HI;
            end
            S_HDR_LO: begin
                if (!accept_s)                         state_next_s = S_HDR_LO;
                else if (hdr_len_s == 16'd0)           state_next_s = S_DONE;
                else if (32'(hdr_len_s) > DEPTH_U)     state_next_s = S_ERR;
                else                                   state_next_s = S_DATA;
            end
            S_DATA: begin
                if (accept_s && (byte_cnt_r == 2'd3)) state_next_s = S_WRITE;
                else                                  state_next_s = S_DATA;
            end
            S_WRITE: begin
                if (last_word_s) state_next_s = S_DONE;
                else             state_next_s = S_DATA;
            end
            S_DONE:  state_next_s = S_DONE;
            S_ERR:   state_next_s = S_ERR;
            default: state_next_s = S_HDR_HI;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= S_HDR_HI;
        else     state_r <= state_next_s;
    end

    // Header/word assembly, word counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_r <= '0;
            byte_cnt_r <= 2'd0;
            len_hi_r   <= 8'd0;
            len_r      <= 16'd0;
            word_r     <= 32'd0;
            cpu_rst_r  <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                case (state_r)
                    S_HDR_HI: len_hi_r <= i_byte;
                    S_HDR_LO: len_r    <= hdr_len_s;
                    S_DATA: begin
                        word_r     <= {word_r[23:0], i_byte};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                    end
                    default: word_r <= word_r;
                endcase
            end
            if (state_r == S_WRITE) word_cnt_r <= word_cnt_r + CW'(1);
            // Status flips on the same edge the sequencer enters its terminal state.
            cpu_rst_r <= (state_next_s != S_DONE);
            done_r    <= (state_next_s == S_DONE);
            err_r     <= (state_next_s == S_ERR);
        end
    end

    // RAM port mux: loader owns it until DONE, then the CPU passes straight through.
    always_comb begin
        ram_wrEn = 1'b0;
        ram_addr = word_cnt_r[SIZE-1:0];
        ram_data = word_r;
        if (rst) begin
            ram_wrEn = 1'b0;
        end else if (state_r == S_DONE) begin
            ram_wrEn = cpu_wrEn;
            ram_addr = cpu_addr;
            ram_data = cpu_data;
        end else begin
            ram_wrEn = (state_r == S_WRITE);
        end
    end

    assign o_byte_ready = ready_s;
    assign o_cpu_rst    = cpu_rst_r;
    assign o_done       = done_r;
    assign o_err        = err_r;

endmodule
